// File: rtl/uart_tx_fifo_if.sv
// Producer / FIFO / UART-transmitter signal bundle for uart_tx_fifo.
// Optional UART_TX_FIFO_OVF_EN adds the sticky overflow flag (ovf) and its clear (ovf_clr).
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [7:0]    push_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovf;
  logic          ovf_clr;
`endif

  // Producer and transmitter side: drives the push strobe and the transmitter status
  modport master (
    output push, push_data, tx_busy, tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    output ovf_clr,
    input  ovf,
`endif
    input  full, empty, count, tx_start, tx_data
  );

  modport slave (
    input  push, push_data, tx_busy, tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    input  ovf_clr,
    output ovf,
`endif
    output full, empty, count, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a launch/wait sequencer.
// Optional UART_TX_FIFO_OVF_EN adds a sticky overflow flag set by discarded pushes.
//
//   state     | meaning
//   IDLE      | waiting for a queued byte and an idle transmitter
//   LAUNCH    | tx_start pulse cycle, tx_data holds the popped byte
//   WAIT_DONE | byte in flight, waiting for tx_done
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == IDLE) && !empty && !bus.tx_busy;
  // A pop on the same edge frees a slot, so a push at full is still accepted
  assign push_ok = bus.push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done) state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ovf_q <= 1'b0;
    else if (bus.push && !push_ok) ovf_q <= 1'b1;
    else if (bus.ovf_clr)          ovf_q <= 1'b0;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-based reference model.
// Build with UART_TX_FIFO_OVF_EN defined to also cover the overflow flag.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a byte queue, the byte currently handed to the transmitter,
  // and where the transfer sits (0 waiting, 1 launch cycle, 2 in flight)
  byte unsigned mq[$];
  int           m_phase;
  logic [7:0]   m_data;
  bit           m_start;
  bit           m_ovf;

  byte unsigned emitted[$];
  int           start_cyc[$];
  int           done_cyc[$];

  int lat       = 5;
  int xmit_cnt  = 0;
  bit xbusy     = 0;
  bit hold_busy = 0;
  bit rnd_lat   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_data  = 8'h00;
    m_start = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge();
    bit pop;
    bit acc;
    pop = (m_phase == 0) && (mq.size() != 0) && !bus.tx_busy;
    acc = bus.push && ((mq.size() < DEPTH) || pop);
`ifdef UART_TX_FIFO_OVF_EN
    if (bus.push && !acc) m_ovf = 1;
    else if (bus.ovf_clr) m_ovf = 0;
`endif
    m_start = 0;
    if (pop) begin
      m_data  = mq.pop_front();
      m_start = 1;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && bus.tx_done) begin
      m_phase = 0;
    end
    if (acc) mq.push_back(bus.push_data);
  endtask

  task automatic compare();
    check_eq("count", 32'(bus.count), mq.size());
    check_eq("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check_eq("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check_eq("tx_start", 32'(bus.tx_start), 32'(m_start));
    check_eq("tx_data", 32'(bus.tx_data), 32'(m_data));
`ifdef UART_TX_FIFO_OVF_EN
    check_eq("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
  endtask

  // One clock: update the model from the inputs seen at the edge, check, then
  // advance the transmitter model (busy from launch until its done pulse)
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    cyc++;
    #1;
    compare();
    if (bus.tx_start) begin
      emitted.push_back(bus.tx_data);
      start_cyc.push_back(cyc);
    end
    bus.tx_done = 1'b0;
    if (xmit_cnt > 0) begin
      xmit_cnt--;
      if (xmit_cnt == 0) begin
        bus.tx_done = 1'b1;
        xbusy = 0;
        done_cyc.push_back(cyc);
      end
    end
    if (bus.tx_start && rst) begin
      xbusy    = 1;
      xmit_cnt = rnd_lat ? int'($urandom_range(1, 8)) : lat;
    end
    bus.tx_busy = xbusy | hold_busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.push      = 1'b1;
    bus.push_data = d;
    step();
    bus.push      = 1'b0;
  endtask

  task automatic drain();
    int  guard;
    bit  busy;
    guard = 0;
    busy  = (mq.size() != 0) || (m_phase != 0) || xbusy;
    while (busy && guard < 5000) begin
      step();
      guard++;
      busy = (mq.size() != 0) || (m_phase != 0) || xbusy;
    end
    check_eq("drain_done", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    int e;
    logic [7:0] exp3 [3];

    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr   = 1'b0;
`endif
    model_reset();
    #3;
    compare();
    run(2);
    rst = 1'b1;
    run(2);

    // Single byte: launch one edge after the push edge, byte held until done
    lat = 20;
    n = start_cyc.size();
    push_byte(8'hA5);
    e = cyc;
    drain();
    check_eq("a5_starts", start_cyc.size() - n, 1);
    if (start_cyc.size() > n) begin
      check_eq("a5_push_to_start", start_cyc[n] - e, 1);
      check_eq("a5_data", 32'(emitted[n]), 32'h A5);
    end
    check_eq("a5_count_end", 32'(bus.count), 0);

    // Fill with the transmitter held busy, then one push beyond full
    hold_busy   = 1;
    bus.tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    push_byte(8'hFF);
    step();
    check_eq("fill_count", 32'(bus.count), 16);
    check_eq("fill_full", 32'(bus.full), 1);
`ifdef UART_TX_FIFO_OVF_EN
    check_eq("fill_ovf", 32'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(bus.ovf), 0);
`endif

    // Push at full on the same edge as a pop
    hold_busy   = 0;
    bus.tx_busy = 1'b0;
    lat = 3;
    n = emitted.size();
    push_byte(8'h77);
    check_eq("pushpop_count", 32'(bus.count), 16);
`ifdef UART_TX_FIFO_OVF_EN
    check_eq("pushpop_ovf", 32'(bus.ovf), 0);
`endif
    drain();
    check_eq("pushpop_emits", emitted.size() - n, 17);
    if (emitted.size() - n == 17)
      for (int k = 0; k < 17; k++)
        check_eq("pushpop_order", 32'(emitted[n + k]), (k < 16) ? 32'(k + 1) : 32'h77);

    // Three bytes through a slow transmitter: each launch 2 edges after a done
    lat = 100;
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    n  = start_cyc.size();
    nd = done_cyc.size();
    for (int k = 0; k < 3; k++) push_byte(exp3[k]);
    drain();
    check_eq("three_starts", start_cyc.size() - n, 3);
    if (start_cyc.size() - n == 3 && done_cyc.size() - nd >= 2) begin
      for (int k = 0; k < 3; k++) check_eq("three_order", 32'(emitted[n + k]), 32'(exp3[k]));
      for (int k = 1; k < 3; k++)
        check_eq("done_to_start", start_cyc[n + k] - done_cyc[nd + k - 1], 2);
    end

    // Wrap: 40 sequential bytes through the 16-entry buffer
    lat = 1;
    n = emitted.size();
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < 50 && bus.full; g++) step();
      push_byte(8'(i));
      repeat ($urandom_range(1, 3)) step();
    end
    drain();
    check_eq("wrap_emits", emitted.size() - n, 40);
    if (emitted.size() - n == 40)
      for (int i = 0; i < 40; i++) check_eq("wrap_order", 32'(emitted[n + i]), 32'(i));

    // Random traffic with random transmitter latency and busy stalls
    rnd_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.push      = ($urandom_range(0, 1) == 1);
      bus.push_data = 8'($urandom);
      hold_busy     = ($urandom_range(0, 7) == 0);
      bus.tx_busy   = xbusy | hold_busy;
`ifdef UART_TX_FIFO_OVF_EN
      bus.ovf_clr   = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    bus.push  = 1'b0;
    hold_busy = 0;
    bus.tx_busy = xbusy;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    drain();
    rnd_lat = 0;

    // Reset mid-transfer with five bytes queued
    lat = 100;
    for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i));
    run(3);
    check_eq("pre_rst_count", 32'(bus.count), 5);
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_start", 32'(bus.tx_start), 0);
    check_eq("rst_data", 32'(bus.tx_data), 0);
    xbusy       = 0;
    xmit_cnt    = 0;
    bus.tx_done = 1'b0;
    bus.tx_busy = 1'b0;
    run(2);
    rst = 1'b1;
    n = start_cyc.size();
    run(150);
    check_eq("no_start_after_rst", start_cyc.size() - n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16: FIFO entries; power of two, 2..256.
REQ-002 SHALL provide port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL provide port push  input  1  write strobe; one byte per cycle while high.
REQ-005 SHALL provide port push_data  input  8  byte written when push=1.
REQ-006 SHALL provide port full  output  1  high when count == DEPTH.
REQ-007 SHALL provide port empty  output  1  high when count == 0.
REQ-008 SHALL provide port count  output  log2(DEPTH)+1  number of stored bytes.
REQ-009 SHALL provide port tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-010 SHALL provide port tx_data  output  8  byte presented to the transmitter.
REQ-011 SHALL provide port tx_busy  input  1  transmitter busy flag.
REQ-012 SHALL provide port tx_done  input  1  transmitter one-cycle completion pulse.

Function
REQ-013 SHALL store bytes in a circular buffer with read and write pointers that wrap from DEPTH-1 to 0; full and empty SHALL derive from count, not pointer equality alone.
REQ-014 SHALL write push_data and increment count on a rising edge where push=1 and full=0.
REQ-015 SHALL discard a push while full=1, leaving the buffer, pointers and count unchanged.
REQ-016 SHALL keep count unchanged and perform both operations when a push and a pop share an edge, including at full: a push at full with a simultaneous pop is accepted.
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT_DONE.
REQ-018 In IDLE with empty=0 and tx_busy=0, the FSM SHALL register tx_data = head byte, pop the head, assert tx_start=1 and enter LAUNCH on the same edge.
REQ-019 LAUNCH SHALL last exactly one cycle, deassert tx_start on exit, and enter WAIT_DONE.
REQ-020 WAIT_DONE SHALL return to IDLE on the edge where tx_done=1; otherwise it SHALL hold.
REQ-021 tx_data SHALL remain stable from the LAUNCH cycle through the tx_done cycle.
REQ-022 tx_start SHALL never be high for two consecutive cycles.
REQ-023 tx_start SHALL never be high in a cycle in which tx_busy was high on the previous edge.
REQ-024 Latency from push into an empty idle FIFO to tx_start high SHALL be 2 cycles: push sampled at edge E, empty=0 after E, tx_start high after E+1.
REQ-025 After tx_done, the next queued byte SHALL launch 2 edges later: IDLE at the first edge, tx_start at the second.
REQ-026 A tx_done received in IDLE or LAUNCH SHALL be ignored.

Reset
REQ-027 While rst=0, SHALL asynchronously force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, tx_start=0, tx_data=8'h00.
REQ-028 Reset asserted mid-transfer SHALL discard all queued bytes and the in-flight byte; after release the block SHALL wait in IDLE and SHALL NOT issue tx_start until a new push.
REQ-029 Buffer contents need not be reset.

Configuration
REQ-030 With macro UART_TX_FIFO_OVF_EN defined, SHALL add output ovf (1) and input ovf_clr (1).
REQ-031 With UART_TX_FIFO_OVF_EN defined, ovf SHALL set on any push discarded per REQ-015 and hold until ovf_clr=1; set wins over a simultaneous clear; reset value 0.
REQ-032 Without UART_TX_FIFO_OVF_EN, ovf and ovf_clr SHALL be absent and discards SHALL be silent.

Verification
REQ-033 Single push 8'hA5 into an empty FIFO, tx_busy=0 -> tx_start pulse 2 cycles later, tx_data=8'hA5, count returns to 0, tx_data held until tx_done.
REQ-034 Push 8'h01..8'h10 (16 bytes, DEPTH=16) with tx_busy held high -> full=1, count=16; 17th push 8'hFF dropped; ovf=1 when UART_TX_FIFO_OVF_EN is defined.
REQ-035 Queue 8'h11, 8'h22, 8'h33; model uart_tx with done pulse 100 cycles after start -> exactly three tx_start pulses, in order, each 2 cycles after the prior tx_done.
REQ-036 At full, push 8'h77 on the same edge as a pop -> count stays 16; 8'h77 is later emitted last; ovf stays 0.
REQ-037 Assert rst=0 during WAIT_DONE with 5 bytes queued -> immediately count=0, empty=1, tx_start=0; no tx_start after release without a new push.
REQ-038 Wrap test: push/pop 40 sequential bytes 8'h00..8'h27 through DEPTH=16 -> emitted order identical, no loss.
